rr_arbiter_8_index: RTL and testbench

Registered 8-requester round-robin arbiter that produces a 3-bit binary grant index plus a valid flag. It sits directly upstream of the 3-to-8 gate-level decoder: `grant_idx` drives the decoder's 3-bit select, and the decoder's one-hot output, qualified by `grant_valid`, becomes the per-requester grant lines. Fairness comes from a rotating priority pointer. A hold-time limit stops any requester from monopolising the grant.

---
 rtl/rr_arbiter_8_index.sv | 105 ++++++++++
 tb/tb_rr_arbiter_8_index.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8_index.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arbiter_8_index : registered 8-way round-robin arbiter, binary grant idx |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
// `release` is a reserved SystemVerilog keyword, so the owner's early-end pulse is named release_req.
module rr_arbiter_8_index #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       release_req,
  input  logic       arb_en,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  localparam logic [7:0] C_HOLD_MAX = 8'(HOLD_MAX);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] grant_idx_q, grant_idx_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       timeout_q, timeout_d;

  logic       w_found;
  logic [2:0] w_winner;
  logic [2:0] w_scan;
  logic       w_req_drop;
  logic       w_hold_hit;

  // Scan req starting at ptr, wrapping mod 8; the 3-bit add does the wrap.
  always_comb begin
    w_found  = 1'b0;
    w_winner = ptr_q;
    w_scan   = ptr_q;
    for (int i = 0; i < 8; i++) begin
      w_scan = ptr_q + 3'(i);
      if (!w_found && req[w_scan]) begin
        w_found  = 1'b1;
        w_winner = w_scan;
      end
    end
  end

  assign w_req_drop = ~req[grant_idx_q];
  assign w_hold_hit = (hold_cnt_q == C_HOLD_MAX);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_idx_d = grant_idx_q;
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_en && w_found) begin
          grant_idx_d = w_winner;
          hold_cnt_d  = 8'd1;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (w_req_drop || release_req || w_hold_hit) begin
          state_d   = IDLE;
          ptr_d     = grant_idx_q + 3'd1;
          // Timeout is flagged only when the hold limit alone ended the grant.
          timeout_d = w_hold_hit && !w_req_drop && !release_req;
        end else if (hold_cnt_q != 8'hFF) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd0;
      grant_idx_q <= 3'd0;
      hold_cnt_q  <= 8'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_idx_q <= grant_idx_d;
      hold_cnt_q  <= hold_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign grant_idx   = grant_idx_q;
  assign grant_valid = (state_q == GRANT);
  assign timeout     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_8_index.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rr_arbiter_8_index : randomized bench with behavioural reference model  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_rr_arbiter_8_index;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       rel = 1'b0;
  logic       arb_en = 1'b0;

  logic [2:0] gi4, gi1;
  logic       gv4, gv1, to4, to1;

  always #5 clk = ~clk;

  rr_arbiter_8_index #(.HOLD_MAX(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .release_req(rel), .arb_en(arb_en),
    .grant_idx(gi4), .grant_valid(gv4), .timeout(to4)
  );

  rr_arbiter_8_index #(.HOLD_MAX(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .release_req(rel), .arb_en(arb_en),
    .grant_idx(gi1), .grant_valid(gv1), .timeout(to1)
  );

  // Reference model: owner, how many cycles it has held, next starting point.
  int hm[2] = '{4, 1};
  int m_valid[2], m_idx[2], m_ptr[2], m_len[2], m_to[2];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 0; m_idx[k] = 0; m_ptr[k] = 0; m_len[k] = 0; m_to[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (m_valid[k] == 0) begin
        m_to[k] = 0;
        if (arb_en && req != 8'h00) begin
          for (int d = 0; d < 8; d++) begin
            if (m_valid[k] == 0 && req[(m_ptr[k] + d) % 8]) begin
              m_idx[k]   = (m_ptr[k] + d) % 8;
              m_valid[k] = 1;
              m_len[k]   = 1;
            end
          end
        end
      end else begin
        bit a, b, c;
        a = !req[m_idx[k]];
        b = rel;
        c = (m_len[k] >= hm[k]);
        if (a || b || c) begin
          m_valid[k] = 0;
          m_ptr[k]   = (m_idx[k] + 1) % 8;
          m_to[k]    = (c && !a && !b) ? 1 : 0;
        end else begin
          m_len[k] = m_len[k] + 1;
          m_to[k]  = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    check_val("idx_h4",   int'(gi4), m_idx[0]);
    check_val("valid_h4", int'(gv4), m_valid[0]);
    check_val("tmo_h4",   int'(to4), m_to[0]);
    check_val("idx_h1",   int'(gi1), m_idx[1]);
    check_val("valid_h1", int'(gv1), m_valid[1]);
    check_val("tmo_h1",   int'(to1), m_to[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    bit hit;
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Full request load: rotation 0..7 with HOLD_MAX-long grants.
    req = 8'hFF; arb_en = 1'b1;
    repeat (50) tick();

    // Wrap-around after owner 5.
    req = 8'h20;
    repeat (8) tick();
    req = 8'h03;
    repeat (14) tick();

    // arb_en gating, then dropping it mid-grant.
    req = 8'h00; repeat (3) tick();
    arb_en = 1'b0; req = 8'h10;
    repeat (10) tick();
    arb_en = 1'b1; repeat (2) tick();
    arb_en = 1'b0; repeat (6) tick();
    arb_en = 1'b1;

    // Single-cycle grants alternating between the two ends.
    req = 8'h81;
    repeat (12) tick();

    // Release coinciding with the hold-limit cycle.
    req = 8'hFF; hit = 0;
    for (int n = 0; n < 20 && !hit; n++) begin
      if (m_valid[0] != 0 && m_len[0] == 4) begin
        rel = 1'b1; tick(); rel = 1'b0; hit = 1;
      end else tick();
    end
    if (!hit) check_val("rel_tmo_wait", 0, 1);
    repeat (3) tick();

    // Early release on the second grant cycle of owner 2.
    req = 8'h00; repeat (3) tick();
    req = 8'h04; hit = 0;
    for (int n = 0; n < 20 && !hit; n++) begin
      if (m_valid[0] != 0 && m_len[0] == 2) begin
        rel = 1'b1; tick(); rel = 1'b0; hit = 1;
      end else tick();
    end
    if (!hit) check_val("rel_wait", 0, 1);
    repeat (3) tick();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(3) == 0) begin
        case ($urandom_range(3))
          0: req = 8'hFF;
          1: req = 8'(1 << $urandom_range(7));
          default: req = 8'($urandom);
        endcase
      end
      rel    = ($urandom_range(5) == 0);
      arb_en = ($urandom_range(4) != 0);
      tick();
    end
    rel = 1'b0; arb_en = 1'b1;

    // Asynchronous reset in the middle of owner 5's grant.
    req = 8'h00; repeat (3) tick();
    req = 8'h20; hit = 0;
    for (int n = 0; n < 40 && !hit; n++) begin
      tick();
      if (m_valid[0] != 0 && m_idx[0] == 5 && m_len[0] == 2) hit = 1;
    end
    if (!hit) check_val("rst_wait", 0, 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_val("post_rst_idx", int'(gi4), 5);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
